// File: rtl/md_div_unit.sv
`timescale 1ns/1ps
// md_div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Answers WIDTH+2 cycles after acceptance (1 cycle for divide-by-zero and
// signed overflow) with a one-cycle done pulse and a held Result.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           request strobe, accepted in IDLE or DONE
//   funct3[2:0]     100 DIV, 101 DIVU, 110 REM, 111 REMU
//   A, B            dividend (rs1), divisor (rs2)
//   kill            pipeline flush, aborts the operation in flight
//   busy            high while an accepted operation is iterating or fixing up
//   done            one-cycle completion pulse
//   Result          quotient or remainder, held until the next completion
module md_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;

  // Acceptance-time decode of the incoming request
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             b_zero;
  logic             ovf;
  logic [WIDTH-1:0] special_res;

  assign op_signed   = ~funct3[0];
  assign a_neg       = op_signed & A[WIDTH-1];
  assign b_neg       = op_signed & B[WIDTH-1];
  assign a_abs       = a_neg ? (~A + WIDTH'(1)) : A;
  assign b_abs       = b_neg ? (~B + WIDTH'(1)) : B;
  assign b_zero      = (B == '0);
  assign ovf         = op_signed & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == '1);
  // Divide-by-zero: q = all ones, r = A. Signed overflow: q = A (min int), r = 0.
  assign special_res = b_zero ? (funct3[1] ? A : '1) : (funct3[1] ? '0 : A);

  // Bit 2 only separates divides from multiplies upstream
  logic unused_f3;
  assign unused_f3 = funct3[2];

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor.
  // rem stays below dvs, so its top bit is zero and {rem, quo msb} is the shifted value.
  logic [WIDTH+1:0] diff;
  logic             trial_ok;

  assign diff     = {rem, quo[WIDTH-1]} - {2'b00, dvs};
  assign trial_ok = ~diff[WIDTH+1];

  // Sign fix-up of the selected result
  logic [WIDTH-1:0] sel_val;
  logic             sel_neg;
  logic [WIDTH-1:0] fix_val;

  assign sel_val = is_rem ? rem[WIDTH-1:0] : quo;
  assign sel_neg = is_rem ? neg_r : neg_q;
  assign fix_val = sel_neg ? (~sel_val + WIDTH'(1)) : sel_val;

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= '0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              is_rem <= funct3[1];
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              cnt    <= '0;
              if (b_zero || ovf) begin
                Result <= special_res;
                done   <= 1'b1;
                busy   <= 1'b0;
                state  <= S_DONE;
              end else begin
                rem   <= '0;
                quo   <= a_abs;
                dvs   <= b_abs;
                busy  <= 1'b1;
                state <= S_RUN;
              end
            end else begin
              state <= S_IDLE;
            end
          end
          S_RUN: begin
            quo <= {quo[WIDTH-2:0], trial_ok};
            rem <= trial_ok ? diff[WIDTH:0] : {rem[WIDTH-1:0], quo[WIDTH-1]};
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              state <= S_FIX;
            end
          end
          S_FIX: begin
            Result <= fix_val;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_DONE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_div_unit.sv
`timescale 1ns/1ps
// Self-checking bench for md_div_unit: scoreboard queue of expected results
// and latencies, one task per scenario.
module tb_md_div_unit;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 2;
  localparam int          MAX_WAIT = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   funct3;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         kill;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;

  md_div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .A      (A),
    .B      (B),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_res;

  // Reference model using the simulator's own signed/unsigned arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    case (f[1:0])
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return LAT;
  endfunction

  // Drive a request for the coming edge and record what it must produce
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input int el);
    exp_t e;
    e.res  = er;
    e.lat  = el;
    funct3 = f;
    A      = a;
    B      = b;
    start  = 1'b1;
    exp_q.push_back(e);
  endtask

  // Step cycles until done; n is the cycle index of the done pulse (1 = cycle after E0).
  // If restart_at > 0, a second request (REMU 5/3) is strobed during that cycle.
  task automatic wait_done(input int restart_at, output int n, output int bcnt,
                           output logic busy_at_done, output bit to);
    n    = 0;
    bcnt = 0;
    to   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1) begin
      if (busy === 1'b1) bcnt++;
      if (n >= MAX_WAIT) begin
        to = 1'b1;
        break;
      end
      if (n == restart_at) begin
        start  = 1'b1;
        funct3 = 3'b111;
        A      = 32'd5;
        B      = 32'd3;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'b000; A = '0; B = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (Result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", Result); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_release: busy=%b done=%b want 0 0", busy, done); end
    last_res = 32'd0;
  endtask

  task automatic test_div_signed();
    int n, bc; logic bd; bit to; exp_t e;
    issue(3'b100, 32'hFFFF_FFEC, 32'd4, 32'hFFFF_FFFB, LAT);
    wait_done(0, n, bc, bd, to);
    e = exp_q.pop_front();
    total++; if (to) begin bad++; $display("FAIL div_signed_timeout: no done in %0d cycles", n); end
    else begin
      total++; if (Result !== e.res) begin bad++; $display("FAIL div_signed_result: got %h want %h", Result, e.res); end
      total++; if (n !== e.lat) begin bad++; $display("FAIL div_signed_latency: got %0d want %0d", n, e.lat); end
      total++; if (bc !== LAT - 1) begin bad++; $display("FAIL div_signed_busy_cycles: got %0d want %0d", bc, LAT - 1); end
      total++; if (bd !== 1'b0) begin bad++; $display("FAIL div_signed_busy_at_done: got %b want 0", bd); end
      last_res = e.res;
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL div_signed_done_width: got %b want 0", done); end
      total++; if (Result !== e.res) begin bad++; $display("FAIL div_signed_hold: got %h want %h", Result, e.res); end
    end
  endtask

  task automatic test_ops();
    logic [2:0]  tf[3] = '{3'b111, 3'b110, 3'b101};
    logic [31:0] ta[3] = '{32'd10, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [31:0] tb[3] = '{32'd3, 32'd2, 32'd2};
    logic [31:0] tr[3] = '{32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    int n, bc; logic bd; bit to; exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(tf[i], ta[i], tb[i], tr[i], LAT);
      wait_done(0, n, bc, bd, to);
      e = exp_q.pop_front();
      total++; if (to) begin bad++; $display("FAIL ops_timeout[%0d]: no done in %0d cycles", i, n); end
      else begin
        total++; if (Result !== e.res) begin bad++; $display("FAIL ops_result[%0d]: got %h want %h", i, Result, e.res); end
        total++; if (n !== e.lat) begin bad++; $display("FAIL ops_latency[%0d]: got %0d want %0d", i, n, e.lat); end
        last_res = e.res;
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  tf[5] = '{3'b101, 3'b111, 3'b100, 3'b100, 3'b110};
    logic [31:0] ta[5] = '{32'd123, 32'd123, 32'd123, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb[5] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] tr[5] = '{32'hFFFF_FFFF, 32'd123, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    int n, bc; logic bd; bit to; exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue(tf[i], ta[i], tb[i], tr[i], 1);
      wait_done(0, n, bc, bd, to);
      e = exp_q.pop_front();
      total++; if (to) begin bad++; $display("FAIL special_timeout[%0d]: no done in %0d cycles", i, n); end
      else begin
        total++; if (Result !== e.res) begin bad++; $display("FAIL special_result[%0d]: got %h want %h", i, Result, e.res); end
        total++; if (n !== e.lat) begin bad++; $display("FAIL special_latency[%0d]: got %0d want %0d", i, n, e.lat); end
        total++; if (bc !== 0 || bd !== 1'b0) begin bad++; $display("FAIL special_busy[%0d]: cycles=%0d at_done=%b want 0 0", i, bc, bd); end
        last_res = e.res;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int n, bc; logic bd; bit to; exp_t e; int extra;
    issue(3'b100, 32'd100, 32'd7, 32'd14, LAT);
    wait_done(10, n, bc, bd, to);
    e = exp_q.pop_front();
    total++; if (to) begin bad++; $display("FAIL ignore_timeout: no done in %0d cycles", n); end
    else begin
      total++; if (Result !== e.res) begin bad++; $display("FAIL ignore_result: got %h want %h", Result, e.res); end
      total++; if (n !== e.lat) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", n, e.lat); end
      last_res = e.res;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done === 1'b1) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL ignore_extra_done: got %0d pulses want 0", extra); end
    end
  endtask

  task automatic test_kill();
    int seen;
    seen = 0;
    funct3 = 3'b100; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      kill = (n == 5);
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    kill = 1'b0;
    total++; if (seen !== 0) begin bad++; $display("FAIL kill_done: got %0d pulses want 0", seen); end
    total++; if (Result !== last_res) begin bad++; $display("FAIL kill_result: got %h want %h", Result, last_res); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    funct3 = 3'b100; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 20; n++) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'd0) begin
      bad++; $display("FAIL rstmid_outputs: busy=%b done=%b result=%h want 0 0 0", busy, done, Result);
    end
    rst = 1'b0;
    last_res = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, bc; logic bd; bit to; exp_t e;
    issue(3'b101, 32'd50, 32'd5, 32'd10, LAT);
    wait_done(0, n, bc, bd, to);
    e = exp_q.pop_front();
    total++; if (to) begin bad++; $display("FAIL b2b_first_timeout: no done in %0d cycles", n); end
    else begin
      total++; if (Result !== e.res) begin bad++; $display("FAIL b2b_first_result: got %h want %h", Result, e.res); end
      total++; if (n !== e.lat) begin bad++; $display("FAIL b2b_first_latency: got %0d want %0d", n, e.lat); end
      // Issue in the DONE cycle itself
      issue(3'b111, 32'd50, 32'd7, 32'd1, LAT);
      wait_done(0, n, bc, bd, to);
      e = exp_q.pop_front();
      total++; if (to) begin bad++; $display("FAIL b2b_second_timeout: no done in %0d cycles", n); end
      else begin
        total++; if (Result !== e.res) begin bad++; $display("FAIL b2b_second_result: got %h want %h", Result, e.res); end
        total++; if (n !== e.lat) begin bad++; $display("FAIL b2b_second_spacing: got %0d want %0d", n, e.lat); end
        last_res = e.res;
      end
    end
  endtask

  task automatic test_random();
    int n, bc; logic bd; bit to; exp_t e;
    logic [2:0] f; logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      f = 3'(4 + $urandom_range(0, 3));
      a = $urandom();
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 17));
        1:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
        2:       b = 32'd0;
        default: b = $urandom();
      endcase
      if (i == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; f = 3'b101; end
      issue(f, a, b, ref_res(f, a, b), ref_lat(f, a, b));
      wait_done(0, n, bc, bd, to);
      e = exp_q.pop_front();
      total++; if (to) begin bad++; $display("FAIL rand_timeout[%0d]: no done in %0d cycles", i, n); end
      else begin
        total++; if (Result !== e.res) begin
          bad++; $display("FAIL rand_result[%0d]: f=%b a=%h b=%h got %h want %h", i, f, a, b, Result, e.res);
        end
        total++; if (n !== e.lat) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, n, e.lat); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_div_signed();
    test_ops();
    test_special();
    test_start_ignored();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
